id_stage_elastic: RTL and testbench

Parametrised next-generation MIPS16 instruction decode stage.
- Accepts instructions from IF over a valid/ready handshake.
- Reads the register file through two combinational read ports.
- Resolves BZ in the decode stage.
- Presents a registered decoded bundle to EX over a valid/ready handshake.
- Adds what the fixed-width ID stage lacks: configurable data width, output backpressure, synchronous flush, and an internal load-use interlock with configurable stall depth.

---
 rtl/mips16_id_pkg.sv | 97 +++++++++
 rtl/id_stage_elastic_decoder.sv | 71 +++++++
 rtl/id_stage_elastic.sv | 158 +++++++++++++++
 tb/tb_id_stage_elastic.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_id_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips16_id_pkg
// Purpose  : Shared types for the MIPS16 decode stage. Contents: opcode and
//            ALU command encodings, instruction field positions, the decoded
//            control struct and the decoded-bundle struct.
// Revision : 1.0 - initial release
// ============================================================================
package mips16_id_pkg;

  // Opcode space. Codes 13 and 15 are unused and decode as NOP.
  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SL    = 4'd6,
    OP_SR    = 4'd7,
    OP_SRU   = 4'd8,
    OP_ADDI  = 4'd9,
    OP_LD    = 4'd10,
    OP_ST    = 4'd11,
    OP_LBI   = 4'd12,
    OP_RSV13 = 4'd13,
    OP_BZ    = 4'd14,
    OP_RSV15 = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SL  = 3'd5,
    ALU_SR  = 3'd6,
    ALU_SRU = 3'd7
  } alu_cmd_e;

  // Instruction field positions.
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 9;
  localparam int RS1_MSB  = 8;
  localparam int RS1_LSB  = 6;
  localparam int RS2_MSB  = 5;
  localparam int RS2_LSB  = 3;
  localparam int IMM6_MSB = 5;
  localparam int IMM8_MSB = 7;

  // Widest legal data path; the bundle struct is sized to it and the stage
  // uses the low DATA_W bits.
  localparam int MAX_DATA_W = 32;

  // Operand 2 source. Zero is the all-zero encoding so an all-zero control
  // word is exactly a NOP.
  typedef enum logic [1:0] {
    SRC2_ZERO  = 2'd0,
    SRC2_REG   = 2'd1,
    SRC2_SEXT6 = 2'd2,
    SRC2_ZEXT8 = 2'd3
  } src2_sel_e;

  typedef struct packed {
    alu_cmd_e  alu_cmd;
    logic      src1_from_reg;        // 0 -> operand 1 is zero
    src2_sel_e src2_sel;
    logic      mem_write_en;
    logic      write_back_en;
    logic      write_back_result_mux;
    logic      addr2_is_rd;          // port 2 reads rd instead of rs2
    logic      reads_rs1;
    logic      reads_rs2;
    logic      reads_rd;
    logic      is_ld;
    logic      is_bz;
  } id_ctrl_t;

  localparam id_ctrl_t CTRL_NOP = '0;

  // Decoded bundle handed to EX, sized for the widest data path.
  typedef struct packed {
    alu_cmd_e              alu_cmd;
    logic [MAX_DATA_W-1:0] alu_src1;
    logic [MAX_DATA_W-1:0] alu_src2;
    logic                  mem_write_en;
    logic [MAX_DATA_W-1:0] mem_write_data;
    logic                  write_back_en;
    logic [2:0]            write_back_dest;
    logic                  write_back_result_mux;
  } id_bundle_t;

endpackage
`default_nettype wire

// File: rtl/id_stage_elastic_decoder.sv
`default_nettype none
// ============================================================================
// Module   : id_decoder
// Purpose  : Purely combinational opcode to control-word decode.
// Ports    : instruction - 16-bit instruction word
//            ctrl        - decoded control fields (id_ctrl_t)
// Revision : 1.0 - initial release
// ============================================================================
module id_decoder
  import mips16_id_pkg::*;
(
  input  logic [15:0] instruction,
  output id_ctrl_t    ctrl
);

  opcode_e    op;
  logic [3:0] op_minus_1;

  assign op         = opcode_e'(instruction[OP_MSB:OP_LSB]);
  assign op_minus_1 = instruction[OP_MSB:OP_LSB] - 4'd1;

  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SL, OP_SR, OP_SRU: begin
        // R-type opcodes are laid out so that op-1 is the ALU command.
        ctrl.alu_cmd       = alu_cmd_e'(op_minus_1[2:0]);
        ctrl.src1_from_reg = 1'b1;
        ctrl.src2_sel      = SRC2_REG;
        ctrl.write_back_en = 1'b1;
        ctrl.reads_rs1     = 1'b1;
        ctrl.reads_rs2     = 1'b1;
      end
      OP_ADDI: begin
        ctrl.src1_from_reg = 1'b1;
        ctrl.src2_sel      = SRC2_SEXT6;
        ctrl.write_back_en = 1'b1;
        ctrl.reads_rs1     = 1'b1;
      end
      OP_LD: begin
        ctrl.src1_from_reg         = 1'b1;
        ctrl.src2_sel              = SRC2_SEXT6;
        ctrl.write_back_en         = 1'b1;
        ctrl.write_back_result_mux = 1'b1;
        ctrl.reads_rs1             = 1'b1;
        ctrl.is_ld                 = 1'b1;
      end
      OP_ST: begin
        ctrl.src1_from_reg = 1'b1;
        ctrl.src2_sel      = SRC2_SEXT6;
        ctrl.mem_write_en  = 1'b1;
        ctrl.addr2_is_rd   = 1'b1;
        ctrl.reads_rs1     = 1'b1;
        ctrl.reads_rd      = 1'b1;
      end
      OP_LBI: begin
        ctrl.src2_sel      = SRC2_ZEXT8;
        ctrl.write_back_en = 1'b1;
      end
      OP_BZ: begin
        // Bundle stays a NOP; only the tested register is read.
        ctrl.addr2_is_rd = 1'b1;
        ctrl.reads_rd    = 1'b1;
        ctrl.is_bz       = 1'b1;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_elastic
// Purpose  : MIPS16 decode stage with valid/ready handshakes on both sides,
//            BZ resolution, synchronous flush and a load-use interlock.
// Ports    : clk, rst (async, active-low), flush
//            in_valid/in_ready/instruction        - from IF
//            reg_read_addr_1/2, reg_read_data_1/2 - register file read ports
//            decoding_op_src1/2                   - source regs for hazards
//            branch_taken, branch_offset_imm      - BZ resolution
//            load_stall                           - interlock active
//            out_valid/out_ready + bundle fields  - to EX
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_elastic
  import mips16_id_pkg::*;
#(
  parameter int DATA_W            = 16,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instruction,
  output logic [2:0]        reg_read_addr_1,
  output logic [2:0]        reg_read_addr_2,
  input  logic [DATA_W-1:0] reg_read_data_1,
  input  logic [DATA_W-1:0] reg_read_data_2,
  output logic [2:0]        decoding_op_src1,
  output logic [2:0]        decoding_op_src2,
  output logic              branch_taken,
  output logic [5:0]        branch_offset_imm,
  output logic              load_stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        alu_cmd,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              write_back_en,
  output logic [2:0]        write_back_dest,
  output logic              write_back_result_mux
);

  id_ctrl_t          ctrl;
  logic [2:0]        rd;
  logic [2:0]        rs1;
  logic [2:0]        rs2;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] src1_next;
  logic [DATA_W-1:0] src2_next;
  logic [1:0]        ld_cnt;
  logic [2:0]        ld_dest;
  logic              stall;
  logic              accept;

  id_decoder u_decoder (
    .instruction (instruction),
    .ctrl        (ctrl)
  );

  assign rd  = instruction[RD_MSB:RD_LSB];
  assign rs1 = instruction[RS1_MSB:RS1_LSB];
  assign rs2 = instruction[RS2_MSB:RS2_LSB];

  assign reg_read_addr_1  = rs1;
  assign reg_read_addr_2  = ctrl.addr2_is_rd ? rd : rs2;
  assign decoding_op_src1 = reg_read_addr_1;
  assign decoding_op_src2 = reg_read_addr_2;

  assign imm_sext = {{(DATA_W-6){instruction[IMM6_MSB]}}, instruction[IMM6_MSB:0]};
  assign imm_zext = {{(DATA_W-8){1'b0}}, instruction[IMM8_MSB:0]};

  // Interlock: a pending load destination blocks any instruction that reads
  // it. r0 is an ordinary register here.
  assign stall = (ld_cnt != 2'd0) && in_valid &&
                 ((ctrl.reads_rs1 && (rs1 == ld_dest)) ||
                  (ctrl.reads_rs2 && (rs2 == ld_dest)) ||
                  (ctrl.reads_rd  && (rd  == ld_dest)));

  assign load_stall        = stall;
  assign in_ready          = !flush && !stall && (!out_valid || out_ready);
  assign accept            = in_valid && in_ready;
  assign branch_taken      = accept && ctrl.is_bz && (reg_read_data_2 == '0);
  assign branch_offset_imm = instruction[IMM6_MSB:0];

  assign src1_next = ctrl.src1_from_reg ? reg_read_data_1 : '0;

  always_comb begin
    src2_next = '0;
    case (ctrl.src2_sel)
      SRC2_REG:   src2_next = reg_read_data_2;
      SRC2_SEXT6: src2_next = imm_sext;
      SRC2_ZEXT8: src2_next = imm_zext;
      default:    src2_next = '0;
    endcase
  end

  // Pipeline register. Fields hold after a consume so EX sees stable data
  // even when it samples late; only out_valid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid             <= 1'b0;
      alu_cmd               <= 3'd0;
      alu_src1              <= '0;
      alu_src2              <= '0;
      mem_write_en          <= 1'b0;
      mem_write_data        <= '0;
      write_back_en         <= 1'b0;
      write_back_dest       <= 3'd0;
      write_back_result_mux <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid             <= 1'b1;
      alu_cmd               <= ctrl.alu_cmd;
      alu_src1              <= src1_next;
      alu_src2              <= src2_next;
      mem_write_en          <= ctrl.mem_write_en;
      mem_write_data        <= ctrl.mem_write_en ? reg_read_data_2 : '0;
      write_back_en         <= ctrl.write_back_en;
      write_back_dest       <= ctrl.write_back_en ? rd : 3'd0;
      write_back_result_mux <= ctrl.write_back_result_mux;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Load scoreboard. The countdown runs regardless of output backpressure.
  generate
    if (LOAD_STALL_CYCLES > 0) begin : g_load_sb
      localparam logic [1:0] LD_CNT_INIT = 2'(LOAD_STALL_CYCLES);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ld_cnt  <= 2'd0;
          ld_dest <= 3'd0;
        end else if (flush) begin
          ld_cnt <= 2'd0;
        end else if (accept && ctrl.is_ld) begin
          ld_cnt  <= LD_CNT_INIT;
          ld_dest <= rd;
        end else if (ld_cnt != 2'd0) begin
          ld_cnt <= ld_cnt - 2'd1;
        end
      end
    end else begin : g_no_load_sb
      assign ld_cnt  = 2'd0;
      assign ld_dest = 3'd0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_id_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_elastic
// Purpose  : Directed self-checking bench for id_stage_elastic
//            (DATA_W=16, LOAD_STALL_CYCLES=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage_elastic;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instruction;
  logic [2:0]  reg_read_addr_1;
  logic [2:0]  reg_read_addr_2;
  logic [15:0] reg_read_data_1;
  logic [15:0] reg_read_data_2;
  logic [2:0]  decoding_op_src1;
  logic [2:0]  decoding_op_src2;
  logic        branch_taken;
  logic [5:0]  branch_offset_imm;
  logic        load_stall;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alu_cmd;
  logic [15:0] alu_src1;
  logic [15:0] alu_src2;
  logic        mem_write_en;
  logic [15:0] mem_write_data;
  logic        write_back_en;
  logic [2:0]  write_back_dest;
  logic        write_back_result_mux;

  int tests;
  int fails;
  int bundles;
  int base;

  logic [15:0] regs [8];

  assign reg_read_data_1 = regs[reg_read_addr_1];
  assign reg_read_data_2 = regs[reg_read_addr_2];

  id_stage_elastic #(
    .DATA_W            (16),
    .LOAD_STALL_CYCLES (1)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .instruction           (instruction),
    .reg_read_addr_1       (reg_read_addr_1),
    .reg_read_addr_2       (reg_read_addr_2),
    .reg_read_data_1       (reg_read_data_1),
    .reg_read_data_2       (reg_read_data_2),
    .decoding_op_src1      (decoding_op_src1),
    .decoding_op_src2      (decoding_op_src2),
    .branch_taken          (branch_taken),
    .branch_offset_imm     (branch_offset_imm),
    .load_stall            (load_stall),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .alu_cmd               (alu_cmd),
    .alu_src1              (alu_src1),
    .alu_src2              (alu_src2),
    .mem_write_en          (mem_write_en),
    .mem_write_data        (mem_write_data),
    .write_back_en         (write_back_en),
    .write_back_dest       (write_back_dest),
    .write_back_result_mux (write_back_result_mux)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bundles handed to EX.
  initial bundles = 0;
  always @(posedge clk) begin
    if (rst && out_valid && out_ready) bundles = bundles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    instruction = 16'h0000;
    regs[0] = 16'h0000; regs[1] = 16'h0010; regs[2] = 16'h0005; regs[3] = 16'h0007;
    regs[4] = 16'h0000; regs[5] = 16'h0000; regs[6] = 16'h1234; regs[7] = 16'h0001;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wb_en", write_back_en, 0);
    chk("rst_src1", alu_src1, 0);
    chk("rst_load_stall", load_stall, 0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // ---------------- ADDI r1,r2,-1 ----------------
    instruction = {4'd9, 3'd1, 3'd2, 6'h3F};
    in_valid    = 1'b1;
    #1;
    chk("addi_addr1", reg_read_addr_1, 2);
    tick();
    in_valid = 1'b0;
    chk("addi_valid", out_valid, 1);
    chk("addi_cmd", alu_cmd, 0);
    chk("addi_src1", alu_src1, 16'h0005);
    chk("addi_src2", alu_src2, 16'hFFFF);
    chk("addi_wb_en", write_back_en, 1);
    chk("addi_dest", write_back_dest, 1);
    chk("addi_mux", write_back_result_mux, 0);
    tick();
    chk("addi_consumed", out_valid, 0);

    // ---------------- LD r3,0(r1) then ADD r4,r3,r1 ----------------
    base        = bundles;
    instruction = {4'd10, 3'd3, 3'd1, 6'h00};
    in_valid    = 1'b1;
    tick();
    chk("ld_valid", out_valid, 1);
    chk("ld_mux", write_back_result_mux, 1);
    chk("ld_dest", write_back_dest, 3);
    chk("ld_src1", alu_src1, 16'h0010);
    chk("ld_src2", alu_src2, 16'h0000);
    instruction = {4'd1, 3'd4, 3'd3, 3'd1, 3'd0};
    #1;
    chk("lu_stall", load_stall, 1);
    chk("lu_in_ready", in_ready, 0);
    tick();
    chk("lu_stall_gone", load_stall, 0);
    chk("lu_in_ready2", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_src1", alu_src1, 16'h0007);
    chk("add_src2", alu_src2, 16'h0010);
    chk("add_dest", write_back_dest, 4);
    chk("add_mux", write_back_result_mux, 0);
    tick();
    chk("lu_bundle_count", bundles - base, 2);

    // ---------------- backpressure with SUB pending ----------------
    instruction = {4'd2, 3'd6, 3'd2, 3'd3, 3'd0};
    in_valid    = 1'b1;
    tick();
    out_ready   = 1'b0;
    instruction = {4'd5, 3'd7, 3'd1, 3'd2, 3'd0};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_cmd", alu_cmd, 1);
      chk("bp_src1", alu_src1, 16'h0005);
      chk("bp_src2", alu_src2, 16'h0007);
      chk("bp_dest", write_back_dest, 6);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("xor_cmd", alu_cmd, 4);
    chk("xor_src1", alu_src1, 16'h0010);
    chk("xor_src2", alu_src2, 16'h0005);
    chk("xor_dest", write_back_dest, 7);

    // ---------------- BZ ----------------
    instruction = {4'd14, 3'd5, 3'd0, 6'h3A};
    #1;
    chk("bz_addr2", reg_read_addr_2, 5);
    chk("bz_taken", branch_taken, 1);
    chk("bz_offset", branch_offset_imm, 6'h3A);
    tick();
    chk("bz_valid", out_valid, 1);
    chk("bz_wb_en", write_back_en, 0);
    chk("bz_mem_we", mem_write_en, 0);
    chk("bz_src1", alu_src1, 0);
    chk("bz_src2", alu_src2, 0);
    instruction = {4'd14, 3'd7, 3'd0, 6'h3A};
    #1;
    chk("bz_not_taken", branch_taken, 0);
    tick();

    // ---------------- ST and LBI ----------------
    instruction = {4'd11, 3'd6, 3'd1, 6'h02};
    tick();
    chk("st_src1", alu_src1, 16'h0010);
    chk("st_src2", alu_src2, 16'h0002);
    chk("st_mem_we", mem_write_en, 1);
    chk("st_mem_data", mem_write_data, 16'h1234);
    chk("st_wb_en", write_back_en, 0);
    instruction = {4'd12, 3'd2, 1'b0, 8'hA5};
    tick();
    in_valid = 1'b0;
    chk("lbi_src1", alu_src1, 0);
    chk("lbi_src2", alu_src2, 16'h00A5);
    chk("lbi_wb_en", write_back_en, 1);
    chk("lbi_dest", write_back_dest, 2);
    chk("lbi_mem_we", mem_write_en, 0);
    tick();

    // ---------------- flush with LD pending and consumer stalled --------
    instruction = {4'd10, 3'd3, 3'd1, 6'h00};
    in_valid    = 1'b1;
    tick();
    out_ready   = 1'b0;
    instruction = {4'd1, 3'd4, 3'd3, 3'd1, 3'd0};
    flush       = 1'b1;
    #1;
    chk("fl_stall", load_stall, 1);
    chk("fl_in_ready", in_ready, 0);
    tick();
    chk("fl_valid", out_valid, 0);
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("fl_ld_cnt_clear", load_stall, 0);
    chk("fl_in_ready2", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("fl_consumer_valid", out_valid, 1);
    chk("fl_consumer_dest", write_back_dest, 4);
    tick();

    // ---------------- async reset mid-stall ----------------
    instruction = {4'd10, 3'd3, 3'd1, 6'h00};
    in_valid    = 1'b1;
    tick();
    out_ready   = 1'b0;
    instruction = {4'd1, 3'd4, 3'd3, 3'd1, 3'd0};
    #1;
    chk("ar_pre_stall", load_stall, 1);
    chk("ar_pre_valid", out_valid, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_wb_en", write_back_en, 0);
    chk("ar_dest", write_back_dest, 0);
    chk("ar_src1", alu_src1, 0);
    chk("ar_mux", write_back_result_mux, 0);
    chk("ar_stall", load_stall, 0);
    tick();
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("ar_in_ready", in_ready, 1);
    chk("ar_valid_after", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
